// File: rtl/tpu_io_pkg.sv
// tpu_io_pkg: shared types, codes and the 7-segment decoder for the board-level TPU top.
package tpu_io_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;
    localparam int N = 4;
    localparam logic [1:0] MODE_BTN = 2'b00;
    localparam logic [2:0] ACT_RELU = 3'b001;
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction
endpackage

// File: rtl/tpu_top_io_complete_seg7_mux.sv
// seg7_mux: time-multiplexes a 16-bit value onto four active-low 7-segment digits.
module seg7_mux
    import tpu_io_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0] digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    assign digit = cnt[REFRESH_BITS-1 -: 2];
    assign an    = ~(4'b0001 << digit);
    assign seg   = hex7(value[{digit, 2'b00} +: 4]);
endmodule

// File: rtl/tpu_top_io_complete.sv
// tpu_top_io_complete: button/switch driven 4x4 int8 matrix engine with LED and 7-seg readout.
module tpu_top_io_complete
    import tpu_io_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] switches,
    input  logic        btn_center,
    input  logic        btn_up,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_down,
    output logic [15:0] leds,
    output logic        tpu_busy_led,
    output logic        tpu_done_led,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso
);
    logic [3:0] raw, pulse;
    logic [1:0] mode, sel;
    logic [2:0] act;
    logic [3:0] addr, e;
    logic [1:0] k;
    logic signed [17:0] acc, sum;
    logic signed [15:0] prod;
    logic [15:0] sat, result;
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [15:0] mem_c [16];
    logic abort, start, computing, wr, last;
    state_t state, next;
    logic unused_ok;

    assign unused_ok = ^{uart_rx, spi_sclk, spi_mosi, spi_cs_n, btn_right, switches[13]};
    assign raw = {btn_down, btn_left, btn_up, btn_center};

    // Two sync flops, then a registered rising-edge pulse per button
    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_btn
            logic [2:0] sh;
            logic p;
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    sh <= '0;
                    p  <= 1'b0;
                end else begin
                    sh <= {sh[1:0], raw[b]};
                    p  <= sh[1] & ~sh[2];
                end
            end
            assign pulse[b] = p;
        end
    endgenerate

    assign mode      = switches[15:14];
    assign act       = switches[12:10];
    assign sel       = switches[9:8];
    assign abort     = pulse[0];
    assign computing = (state == COMPUTE);
    assign start     = pulse[1] && (state == IDLE || state == DONE);
    assign wr        = pulse[3] && mode == MODE_BTN && !computing;
    assign last      = computing && k == 2'd3 && e == 4'd15;

    // Element e = row*4+col; A is walked along the row, B down the column
    assign prod   = $signed(mem_a[{e[3:2], k}][15:8]) * $signed(mem_b[{k, e[1:0]}][15:8]);
    assign sum    = acc + {{2{prod[15]}}, prod};
    assign sat    = sum > 18'sd32767 ? 16'h7fff : sum < -18'sd32768 ? 16'h8000 : sum[15:0];
    assign result = (act == ACT_RELU && sat[15]) ? 16'h0000 : sat;

    always_comb next = abort ? IDLE : start ? COMPUTE : last ? DONE : state;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr <= '0;
            e    <= '0;
            k    <= '0;
            acc  <= '0;
            for (int n = 0; n < 16; n++) begin
                mem_a[n] <= '0;
                mem_b[n] <= '0;
                mem_c[n] <= '0;
            end
        end else begin
            if (pulse[2]) addr <= switches[3:0];
            if (wr && sel == SEL_A) mem_a[addr] <= {switches[7:0], 8'h00};
            if (wr && sel == SEL_B) mem_b[addr] <= {switches[7:0], 8'h00};
            if (start) begin
                e   <= '0;
                k   <= '0;
                acc <= '0;
            end else if (computing && !abort) begin
                k   <= k + 1'b1;
                acc <= k == 2'd3 ? 18'sd0 : sum;
                if (k == 2'd3) begin
                    mem_c[e] <= result;
                    e        <= e + 1'b1;
                end
            end
        end
    end

    assign leds = sel == SEL_A ? mem_a[addr] : sel == SEL_B ? mem_b[addr] :
                  sel == SEL_C ? mem_c[addr] : 16'h0000;
    assign tpu_busy_led = computing;
    assign tpu_done_led = (state == DONE);
    assign uart_tx  = 1'b1;
    assign spi_miso = 1'b0;

    seg7_mux #(.REFRESH_BITS(REFRESH_BITS)) u_seg (
        .clk  (clk),
        .rst  (rst_n),
        .value(leds),
        .seg  (seg),
        .an   (an)
    );
endmodule

// File: tb/tb_tpu_top_io_complete.sv
// tb_tpu_top_io_complete: randomized and directed checks of the button-driven TPU top against a matrix model.
module tb_tpu_top_io_complete;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [15:0] switches = '0;
    logic btn_center = 0, btn_up = 0, btn_left = 0, btn_right = 0, btn_down = 0;
    logic uart_rx = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
    logic [15:0] leds;
    logic tpu_busy_led, tpu_done_led, uart_tx, spi_miso;
    logic [6:0] seg;
    logic [3:0] an;

    logic [15:0] ma [16];
    logic [15:0] mb [16];
    logic [15:0] mc [16];
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    logic [2:0] act_v = 3'd0;
    logic [3:0] addr_v = 4'd0;
    int npass = 0, ntot = 0;

    always #5 clk = ~clk;

    tpu_top_io_complete #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches),
        .btn_center(btn_center), .btn_up(btn_up), .btn_left(btn_left),
        .btn_right(btn_right), .btn_down(btn_down),
        .leds(leds), .tpu_busy_led(tpu_busy_led), .tpu_done_led(tpu_done_led),
        .seg(seg), .an(an), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] sw(input logic [1:0] mode, input logic [1:0] sel, input logic [7:0] d);
        return {mode, 1'b0, act_v, sel, d};
    endfunction

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_center = v;
            1: btn_up = v;
            2: btn_left = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press(input int which);
        @(negedge clk) set_btn(which, 1'b1);
        repeat (2) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic latch_addr(input logic [1:0] sel, input logic [3:0] a);
        switches = sw(2'b00, sel, {4'h0, a});
        press(2);
        addr_v = a;
    endtask

    task automatic write_mem(input logic [1:0] mode, input logic [1:0] sel, input logic [3:0] a, input logic [7:0] d);
        latch_addr(sel, a);
        switches = sw(mode, sel, d);
        press(3);
        if (mode == 2'b00 && sel == 2'b00) ma[a] = {d, 8'h00};
        if (mode == 2'b00 && sel == 2'b01) mb[a] = {d, 8'h00};
    endtask

    task automatic read_check(input string tag, input logic [1:0] sel, input logic [3:0] a, input logic [15:0] exp);
        latch_addr(sel, a);
        check(tag, leds, exp);
    endtask

    function automatic logic [15:0] model_c(input int n);
        int s = 0;
        for (int kk = 0; kk < 4; kk++) begin
            byte av = ma[(n / 4) * 4 + kk][15:8];
            byte bv = mb[kk * 4 + n % 4][15:8];
            s += int'(av) * int'(bv);
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (act_v == 3'd1 && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic wait_start(output int lat);
        switches = sw(2'b00, 2'b00, 8'ha5);
        @(negedge clk) btn_up = 1'b1;
        lat = 0;
        while (!tpu_busy_led && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) btn_up = 1'b0;
        end
        btn_up = 1'b0;
        check("start_lat", (lat >= 3 && lat <= 4), 1);
    endtask

    task automatic run(input bit disturb);
        int lat, n;
        wait_start(lat);
        n = 0;
        while (tpu_busy_led && n < 200) begin
            if (disturb && n == 5) begin btn_up = 1'b1; btn_down = 1'b1; end
            if (disturb && n == 7) begin btn_up = 1'b0; btn_down = 1'b0; end
            @(negedge clk);
            n++;
        end
        check("busy_len", n, 64);
        check("done_set", tpu_done_led, 1);
        check("busy_clr", tpu_busy_led, 0);
        for (int i = 0; i < 16; i++) mc[i] = model_c(i);
    endtask

    initial begin
        int lat, n;
        for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; mc[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_leds", leds, 0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        rst_n = 1'b0;
        @(negedge clk);
        check("post_busy", tpu_busy_led, 0);
        check("post_done", tpu_done_led, 0);
        check("post_leds", leds, 0);
        check("post_uart", uart_tx, 1);
        check("post_miso", spi_miso, 0);

        write_mem(2'b00, 2'b00, 4'd0, 8'h3c);
        check("wr_a0", leds, 16'h3c00);
        for (int c = 0; c < 24; c++) begin
            int d = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) d = i;
            check("an_onehot", $countones(~an), 1);
            check("seg_3c00", seg, hex_tab[(16'h3c00 >> (4 * d)) & 16'hf]);
            @(negedge clk);
        end

        for (int i = 0; i < 16; i++) begin
            write_mem(2'b00, 2'b00, 4'(i), (i / 4 == i % 4) ? 8'h01 : 8'h00);
            write_mem(2'b00, 2'b01, 4'(i), 8'(i));
        end
        run(1'b0);
        for (int i = 0; i < 16; i++) read_check("ident_c", 2'b10, 4'(i), 16'(i));

        write_mem(2'b00, 2'b00, 4'd0, 8'hff);
        write_mem(2'b00, 2'b01, 4'd0, 8'h05);
        act_v = 3'd1;
        run(1'b0);
        read_check("relu_c0", 2'b10, 4'd0, 16'h0000);
        act_v = 3'd0;
        run(1'b0);
        read_check("pass_c0", 2'b10, 4'd0, 16'hfffb);

        latch_addr(2'b11, 4'd0);
        check("sel11", leds, 0);
        write_mem(2'b01, 2'b00, 4'd5, 8'h77);
        read_check("mode_ign", 2'b00, 4'd5, ma[5]);
        write_mem(2'b00, 2'b10, 4'd3, 8'h55);
        read_check("c_wr_ign", 2'b10, 4'd3, mc[3]);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                write_mem(2'b00, 2'b00, 4'(i), 8'($urandom));
                write_mem(2'b00, 2'b01, 4'(i), 8'($urandom));
            end
            if (r == 1) for (int kk = 0; kk < 4; kk++) begin
                write_mem(2'b00, 2'b00, 4'(kk), 8'h80);
                write_mem(2'b00, 2'b01, 4'(kk * 4), 8'h80);
                write_mem(2'b00, 2'b00, 4'(4 + kk), 8'h80);
                write_mem(2'b00, 2'b01, 4'(kk * 4 + 1), 8'h7f);
            end
            act_v = (r == 2) ? 3'd1 : 3'($urandom_range(0, 7));
            run(r == 0);
            switches = sw(2'b00, 2'b00, 8'h00);
            @(negedge clk);
            check("disturb_a", leds, ma[addr_v]);
            for (int i = 0; i < 16; i++) read_check("rand_c", 2'b10, 4'(i), mc[i]);
        end

        press(0);
        check("abort_done", tpu_done_led, 0);
        wait_start(lat);
        repeat (10) @(negedge clk);
        btn_center = 1'b1;
        n = 0;
        while (tpu_busy_led && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 2) btn_center = 1'b0;
        end
        btn_center = 1'b0;
        check("abort_busy", tpu_busy_led, 0);
        check("abort_done2", tpu_done_led, 0);
        repeat (80) @(negedge clk);
        check("abort_stay", {tpu_busy_led, tpu_done_led}, 2'b00);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/tpu_top_io_complete.md
# tpu_top_io_complete

Board-level top for the small matrix-multiply TPU: a 4×4 int8 matrix engine with on-chip A/B/C memories, driven entirely from switches and push-buttons. Results and status appear on the 16 LEDs, two status LEDs and a 4-digit 7-segment display. The UART and SPI host ports are present for pin compatibility and held idle in this revision. Sits directly under the FPGA wrapper.

## Interface
- REFRESH_BITS, 16, width of the 7-seg refresh counter; digit select = counter[REFRESH_BITS-1:REFRESH_BITS-2]
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1); port name kept as in the codebase
- switches  in  16  [15:14] mode (00 = button mode), [12:10] activation, [9:8] matrix select (00 A, 01 B, 10 C), [7:0] data/address
- btn_center, btn_up, btn_left, btn_right, btn_down  in  1 each  raw buttons: abort, start, latch address, display hold (reserved, ignored), write
- leds  out  16  word at selected matrix/address
- tpu_busy_led, tpu_done_led  out  1  computing / result valid
- seg  out  7  active-low segments {g..a}; an  out  4  active-low digit enables
- uart_rx in 1, uart_tx out 1 (held 1); spi_sclk, spi_mosi, spi_cs_n in 1, spi_miso out 1 (held 0)

## Operation
- Every button passes through a 2-flop synchroniser and a rising-edge detector; each press yields one 1-cycle pulse.
- Memories: A, B and C are each 16 × 16 bits, element index = row*4+col. Writes store {switches[7:0], 8'h00}.
- btn_left: addr ← switches[3:0].
- btn_down, mode 00, state ≠ COMPUTE, select A or B: write the selected memory at addr. Writes with select = C, or any other mode, are ignored.
- tpu_start = btn_up pulse while state is IDLE or DONE.
- Internal state: IDLE=0, COMPUTE=1, DONE=2.
  - IDLE→COMPUTE on tpu_start.
  - COMPUTE→DONE after the last MAC.
  - DONE→COMPUTE on tpu_start.
  - Any state→IDLE on the btn_center pulse; btn_center takes priority over a simultaneous start.
- computing = (state == COMPUTE).
- Compute: for i, j in 0..3 (row-major), acc = Σk A[i][k][15:8] · B[k][j][15:8], as a signed int8×int8 sum in 18 bits; one MAC per cycle.
  - After k = 3, saturate acc to signed 16 bits.
  - Apply activation: 001 = ReLU (negative → 0); all other codes pass through.
  - Write the result to C[i*4+j].
- Abort mid-compute leaves already-written C elements; unwritten elements keep their old values.
- leds = selected memory at addr (select 11 → 0), continuously.
- 7-seg: shows leds as 4 hex digits; digit 0 = leds[3:0] on an[0]. Standard hex patterns, active-low.
- tpu_busy_led = computing. tpu_done_led = (state == DONE); it clears on the next start or abort.

## Timing
- Reset values: state IDLE, addr 0, all memories 0, leds 0, busy 0, done 0, refresh counter 0, an = 4'b1110, seg = pattern for "0" (7'b1000000), uart_tx 1, spi_miso 0.
- Button-to-pulse: the pulse fires on the 3rd rising edge after the raw button goes high (2 sync + edge detect).
- Start: state = COMPUTE on the cycle after the tpu_start pulse.
- Compute length: exactly 64 cycles in COMPUTE (16 elements × 4 MACs). The final C write and the DONE transition occur on the same edge.
- Memory write: visible on leds the cycle after the write pulse. The C write is visible on leds the next cycle.
- Start or write pulses during COMPUTE are ignored; the result does not restart.

## Structure
- Package tpu_io_pkg holds:
  - state enum (IDLE/COMPUTE/DONE)
  - N = 4
  - mode and activation codes
  - matrix-select codes
  - hex-to-7seg function
- Sub-module seg7_mux (refresh counter, digit select, decode).
- Button conditioning (sync + edge detect): a generate loop, not a separate block.

## Test plan
- Reset held, then released → state 0, busy 0, done 0, leds 0, an 1110, uart_tx 1.
- switches = 0x0000, btn_left pulse, switches[7:0] = 0x3C, btn_down pressed for 2 cycles → A[0] = 0x3C00; leds = 0x3C00 with select 00; 7-seg shows "3C00".
- btn_up pressed for 2 cycles → tpu_start pulses once, 3 cycles later. busy = 1 for 64 cycles, then done = 1, state = 2 (well inside 1000 ns).
- A = identity (0x0100 on diagonal), B[k][j] = (k*4+j)<<8, start → C[n] = n for all n; select 10 reads them back.
- A[0] = 0xFF00 (−1), B[0] = 0x0500, activation 001 → C[0] = 0. With activation 000 → C[0] = 0xFFFB.
- btn_center during COMPUTE → state 0, busy 0, done 0. btn_up or btn_down during COMPUTE → ignored, memory unchanged.
